// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the per-source result handshake (valid / result / tag / ready) and
// the registered Common Data Bus broadcast (CDB / Qi_CDB / CDB_Valid).
//   slave  : the arbiter side (consumes results, drives the broadcast)
//   master : the producer/consumer side (drives results, observes broadcast)
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
);
    logic [N_SRC-1:0]        Src_Valid;
    logic [N_SRC*DATA_W-1:0] Src_Result;
    logic [N_SRC*TAG_W-1:0]  Src_Tag;
    logic [N_SRC-1:0]        Src_Ready;
    logic [DATA_W-1:0]       CDB;
    logic [TAG_W-1:0]        Qi_CDB;
    logic                    CDB_Valid;

    modport slave (
        input  Src_Valid,
        input  Src_Result,
        input  Src_Tag,
        output Src_Ready,
        output CDB,
        output Qi_CDB,
        output CDB_Valid
    );

    modport master (
        output Src_Valid,
        output Src_Result,
        output Src_Tag,
        input  Src_Ready,
        input  CDB,
        input  Qi_CDB,
        input  CDB_Valid
    );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Common Data Bus arbiter. Each source owns one holding slot (full bit, value,
// tag). Every cycle one full slot is picked round-robin starting at r_ptr and
// broadcast as a registered CDB value plus producer tag. A slot being
// broadcast accepts a new result at the same edge, so a single source can
// stream one result per cycle. Tag 0 means "no producer" and is never taken.
//
// Optional feature (macro CDB_STATS_EN): adds a saturating 16-bit
// Conflict_Count output that counts edges at which two or more slots were
// already full. It is cleared by Reset only, not by Flush.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int                N_SRC      = 4,
    parameter int                DATA_W     = 16,
    parameter int                TAG_W      = 3,
    parameter logic [DATA_W-1:0] IDLE_VALUE = DATA_W'(16'hFFF0)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Flush,
    cdb_arbiter_if.slave  bus
`ifdef CDB_STATS_EN
    ,
    output logic [15:0]   Conflict_Count
`endif
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [TAG_W-1:0]  tag;
    } slot_t;

    // Slot state and registered broadcast
    logic [N_SRC-1:0]  r_full;
    slot_t             r_slot [N_SRC];
    logic [PTR_W-1:0]  r_ptr;
    logic [DATA_W-1:0] r_cdb;
    logic [TAG_W-1:0]  r_qi;
    logic              r_cdb_valid;

    // Arbitration and handshake
    logic [N_SRC-1:0]  w_grant;
    logic              w_grant_any;
    logic [PTR_W-1:0]  w_grant_idx;
    logic [PTR_W-1:0]  w_ptr_next;
    logic [PTR_W:0]    w_scan_sum;
    logic [PTR_W-1:0]  w_scan_idx;
    logic [N_SRC-1:0]  w_ready;
    logic [N_SRC-1:0]  w_capture;

    // Round-robin scan: first full slot at or after r_ptr, wrapping modulo N_SRC.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan_sum  = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_scan_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_scan_sum >= (PTR_W+1)'(N_SRC)) begin
                w_scan_sum = w_scan_sum - (PTR_W+1)'(N_SRC);
            end
            w_scan_idx = w_scan_sum[PTR_W-1:0];
            if (!w_grant_any && r_full[w_scan_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    // Pointer advances to the slot just past the winner; it holds when idle.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_grant_any) begin
            w_ptr_next = (w_grant_idx == PTR_W'(N_SRC - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // A slot accepts when empty or when it is being drained this cycle.
    assign w_ready = ~r_full | w_grant;

    // A result is taken only when valid, accepted and carrying a real producer tag.
    always_comb begin
        w_capture = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_capture[i] = bus.Src_Valid[i] & w_ready[i]
                         & (bus.Src_Tag[i*TAG_W +: TAG_W] != '0);
        end
    end

    // Slot occupancy, round-robin pointer and the registered CDB broadcast.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_full      <= '0;
            r_ptr       <= '0;
            r_cdb       <= IDLE_VALUE;
            r_qi        <= '0;
            r_cdb_valid <= 1'b0;
        end else if (Flush) begin
            r_full      <= '0;
            r_ptr       <= '0;
            r_cdb       <= IDLE_VALUE;
            r_qi        <= '0;
            r_cdb_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, so the drained slot and the new capture resolve correctly.
            r_full <= (r_full & ~w_grant) | w_capture;
            r_ptr  <= w_ptr_next;
            if (w_grant_any) begin
                r_cdb       <= r_slot[w_grant_idx].value;
                r_qi        <= r_slot[w_grant_idx].tag;
                r_cdb_valid <= 1'b1;
            end else begin
                r_cdb       <= IDLE_VALUE;
                r_qi        <= '0;
                r_cdb_valid <= 1'b0;
            end
        end
    end

    // Slot payload loads on capture; whether it is meaningful is tracked by r_full.
    // NOTE: payload storage has no reset because r_full gates every read, so stale contents never reach the bus.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (w_capture[i]) begin
                r_slot[i].value <= bus.Src_Result[i*DATA_W +: DATA_W];
                r_slot[i].tag   <= bus.Src_Tag[i*TAG_W +: TAG_W];
            end
        end
    end

    assign bus.Src_Ready = w_ready;
    assign bus.CDB       = r_cdb;
    assign bus.Qi_CDB    = r_qi;
    assign bus.CDB_Valid = r_cdb_valid;

`ifdef CDB_STATS_EN
    localparam int CNT_W = (N_SRC < 3) ? 2 : $clog2(N_SRC + 1);

    logic [CNT_W-1:0] w_full_count;
    logic [15:0]      r_conflict_count;

    // Number of slots already occupied before this edge's captures.
    always_comb begin
        w_full_count = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_full_count = w_full_count + CNT_W'(r_full[i]);
        end
    end

    // Saturating contention counter; survives Flush, cleared by Reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_conflict_count <= '0;
        end else if ((w_full_count >= CNT_W'(2)) && (r_conflict_count != 16'hFFFF)) begin
            r_conflict_count <= r_conflict_count + 16'd1;
        end
    end

    assign Conflict_Count = r_conflict_count;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed scenarios followed by a randomized phase. A behavioural model of
// the slots (arrays indexed by source) predicts Src_Ready before each edge
// and the broadcast after it. Conflict_Count is checked when CDB_STATS_EN is
// defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdb_arbiter;

    localparam int          N    = 4;
    localparam int          DW   = 16;
    localparam int          TW   = 3;
    localparam logic [15:0] IDLE = 16'hFFF0;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_SRC(N), .DATA_W(DW), .TAG_W(TW)) bus ();

`ifdef CDB_STATS_EN
    logic [15:0] conflict_count;
`endif

    cdb_arbiter #(
        .N_SRC      (N),
        .DATA_W     (DW),
        .TAG_W      (TW),
        .IDLE_VALUE (IDLE)
    ) dut (
        .Clock          (clk),
        .Reset          (rst_n),
        .Flush          (flush),
        .bus            (bus)
`ifdef CDB_STATS_EN
        ,
        .Conflict_Count (conflict_count)
`endif
    );

    // Reference model state
    bit            m_full [N];
    logic [DW-1:0] m_val  [N];
    logic [TW-1:0] m_tag  [N];
    int            m_ptr;
    logic [DW-1:0] m_cdb;
    logic [TW-1:0] m_qi;
    logic          m_valid;
    int            m_conf;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        m_ptr   = 0;
        m_cdb   = IDLE;
        m_qi    = '0;
        m_valid = 1'b0;
    endtask

    task automatic set_src(input int i, input logic v, input logic [DW-1:0] r, input logic [TW-1:0] t);
        bus.Src_Valid[i]           = v;
        bus.Src_Result[i*DW +: DW] = r;
        bus.Src_Tag[i*TW +: TW]    = t;
    endtask

    task automatic clear_src();
        bus.Src_Valid  = '0;
        bus.Src_Result = '0;
        bus.Src_Tag    = '0;
    endtask

    // One clock: predict ready, advance the model across the edge, compare outputs.
    task automatic cycle();
        int            g;
        int            idx;
        int            nfull;
        logic [N-1:0]  exp_ready;
        logic [TW-1:0] in_tag;
        #1;
        g     = -1;
        nfull = 0;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && m_full[idx]) g = idx;
            if (m_full[k]) nfull++;
        end
        for (int i = 0; i < N; i++) exp_ready[i] = !m_full[i] || (g == i);
        check("src_ready", 32'(bus.Src_Ready), 32'(exp_ready));

        if (!rst_n) begin
            model_reset();
            m_conf = 0;
        end else begin
            if (nfull >= 2 && m_conf < 65535) m_conf++;
            if (flush) begin
                model_reset();
            end else begin
                if (g >= 0) begin
                    m_cdb     = m_val[g];
                    m_qi      = m_tag[g];
                    m_valid   = 1'b1;
                    m_full[g] = 1'b0;
                    m_ptr     = (g + 1) % N;
                end else begin
                    m_cdb   = IDLE;
                    m_qi    = '0;
                    m_valid = 1'b0;
                end
                for (int i = 0; i < N; i++) begin
                    in_tag = bus.Src_Tag[i*TW +: TW];
                    if (bus.Src_Valid[i] && exp_ready[i] && in_tag != '0) begin
                        m_full[i] = 1'b1;
                        m_val[i]  = bus.Src_Result[i*DW +: DW];
                        m_tag[i]  = in_tag;
                    end
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        check("cdb",       32'(bus.CDB),       32'(m_cdb));
        check("qi_cdb",    32'(bus.Qi_CDB),    32'(m_qi));
        check("cdb_valid", 32'(bus.CDB_Valid), 32'(m_valid));
`ifdef CDB_STATS_EN
        check("conflict_count", 32'(conflict_count), 32'(m_conf));
`endif
    endtask

    initial begin
        int            cnt_a;
        int            cnt_b;
        logic [DW-1:0] seen [6];

        rst_n = 1'b0;
        flush = 1'b0;
        clear_src();
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        m_conf = 0;

        // Reset state
        check("rst_cdb",   32'(bus.CDB),       32'(IDLE));
        check("rst_qi",    32'(bus.Qi_CDB),    32'd0);
        check("rst_valid", 32'(bus.CDB_Valid), 32'd0);
        check("rst_ready", 32'(bus.Src_Ready), 32'hF);
`ifdef CDB_STATS_EN
        check("rst_conflict", 32'(conflict_count), 32'd0);
`endif
        rst_n = 1'b1;

        // Single source: one result, broadcast one cycle later, then idle.
        set_src(1, 1'b1, 16'h0042, 3'd3);
        cycle();
        clear_src();
        cycle();
        check("single_cdb",   32'(bus.CDB),       32'h0042);
        check("single_qi",    32'(bus.Qi_CDB),    32'd3);
        check("single_valid", 32'(bus.CDB_Valid), 32'd1);
        cycle();
        check("single_idle_cdb",   32'(bus.CDB),       32'(IDLE));
        check("single_idle_qi",    32'(bus.Qi_CDB),    32'd0);
        check("single_idle_valid", 32'(bus.CDB_Valid), 32'd0);

        // Contention: return ptr to 0, then all four sources at once.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        for (int i = 0; i < N; i++) set_src(i, 1'b1, DW'(16'h0100 + i), TW'(i + 1));
        cycle();
        clear_src();
        for (int k = 0; k < N; k++) begin
            cycle();
            check("contention_qi", 32'(bus.Qi_CDB), 32'(k + 1));
        end
`ifdef CDB_STATS_EN
        check("contention_conflict", 32'(conflict_count), 32'd3);
`endif

        // Fairness: sources 0 and 2 request continuously.
        cnt_a = 0;
        cnt_b = 0;
        set_src(0, 1'b1, 16'hA000, 3'd1);
        set_src(2, 1'b1, 16'hA002, 3'd6);
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (bus.CDB_Valid === 1'b1 && bus.Qi_CDB === 3'd1) cnt_a++;
            if (bus.CDB_Valid === 1'b1 && bus.Qi_CDB === 3'd6) cnt_b++;
        end
        check("fair_src0_count", 32'(cnt_a), 32'd5);
        check("fair_src2_count", 32'(cnt_b), 32'd4);
        clear_src();
        repeat (3) cycle();

        // Streaming: source 2 alone, one result per cycle.
        for (int k = 0; k < 5; k++) begin
            set_src(2, 1'b1, DW'(k + 1), 3'd5);
            cycle();
            check("stream_ready2", 32'(bus.Src_Ready[2]), 32'd1);
            seen[k] = bus.CDB;
        end
        clear_src();
        cycle();
        seen[5] = bus.CDB;
        for (int j = 1; j <= 5; j++) check("stream_cdb", 32'(seen[j]), 32'(j));

        // Tag 0 is never captured.
        set_src(0, 1'b1, 16'h1234, 3'd0);
        cycle();
        cycle();
        check("tag0_valid", 32'(bus.CDB_Valid), 32'd0);
        check("tag0_cdb",   32'(bus.CDB),       32'(IDLE));
        check("tag0_ready", 32'(bus.Src_Ready), 32'hF);
        clear_src();

        // Reset mid-operation with three slots full and ptr away from 0.
        for (int i = 0; i < 3; i++) set_src(i, 1'b1, DW'(16'h0200 + i), TW'(i + 1));
        cycle();
        clear_src();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("rst_mid_valid", 32'(bus.CDB_Valid), 32'd0);
        check("rst_mid_ready", 32'(bus.Src_Ready), 32'hF);
        set_src(1, 1'b1, 16'h0301, 3'd2);
        set_src(3, 1'b1, 16'h0303, 3'd7);
        cycle();
        clear_src();
        cycle();
        check("rst_mid_first_qi", 32'(bus.Qi_CDB), 32'd2);
        cycle();
        check("rst_mid_second_qi", 32'(bus.Qi_CDB), 32'd7);
        cycle();
        check("rst_mid_idle", 32'(bus.CDB_Valid), 32'd0);

        // Flush mid-operation; a capture attempted at the flush edge is dropped.
        for (int i = 0; i < 3; i++) set_src(i, 1'b1, DW'(16'h0400 + i), TW'(i + 1));
        cycle();
        clear_src();
        cycle();
        cycle();
        flush = 1'b1;
        set_src(0, 1'b1, 16'h0BAD, 3'd5);
        cycle();
        flush = 1'b0;
        clear_src();
        check("flush_valid", 32'(bus.CDB_Valid), 32'd0);
        check("flush_cdb",   32'(bus.CDB),       32'(IDLE));
        check("flush_ready", 32'(bus.Src_Ready), 32'hF);
        set_src(1, 1'b1, 16'h0501, 3'd2);
        set_src(3, 1'b1, 16'h0503, 3'd7);
        cycle();
        clear_src();
        cycle();
        check("flush_first_qi", 32'(bus.Qi_CDB), 32'd2);
        cycle();
        check("flush_second_qi", 32'(bus.Qi_CDB), 32'd7);
        cycle();
        check("flush_idle", 32'(bus.CDB_Valid), 32'd0);

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                set_src(i, ($urandom_range(0, 3) != 0), DW'($urandom), TW'($urandom_range(0, 7)));
            end
            flush = ($urandom_range(0, 31) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
            cycle();
        end
        flush = 1'b0;
        rst_n = 1'b1;
        clear_src();
        repeat (6) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Common Data Bus arbiter. It sits directly downstream of the reservation stations and functional units, and upstream of the register file and reservation-station operand capture.
- Buffers one completed result per source.
- Picks one result per cycle with round-robin arbitration.
- Broadcasts the result as registered CDB value plus producer tag (Qi_CDB), which consumers compare against their pending Qi/Qj/Qk tags.

Parameters:
N_SRC, 4, number of result sources (reservation stations / FUs)
DATA_W, 16, result width
TAG_W, 3, producer tag width; tag 0 reserved = "no producer"
IDLE_VALUE, 16'hFFF0, value driven on CDB when nothing is broadcast

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-low reset
Flush  input  1  synchronous clear of all pending results (active-high)
Src_Valid  input  N_SRC  per-source result valid
Src_Result  input  N_SRC*DATA_W  per-source result, source i at [i*DATA_W +: DATA_W]
Src_Tag  input  N_SRC*TAG_W  per-source producer tag, source i at [i*TAG_W +: TAG_W]
Src_Ready  output  N_SRC  per-source accept
CDB  output  DATA_W  broadcast result (registered)
Qi_CDB  output  TAG_W  broadcast tag (registered); 0 when idle
CDB_Valid  output  1  broadcast valid (registered)

Behaviour:
- Interface: one clock (Clock). Reset is synchronous and active-low: all state is cleared on a rising Clock edge with Reset==0.
- Reset values:
  - CDB=IDLE_VALUE, Qi_CDB=0, CDB_Valid=0.
  - All slots empty; round-robin pointer ptr=0.
  - Src_Ready = all ones in the cycle after reset.
- Storage: one holding slot per source: full bit, DATA_W value, TAG_W tag.
- Grant (combinational):
  - Scan full slots starting at index ptr, wrapping modulo N_SRC.
  - The first full slot found gets grant[i]=1. At most one grant per cycle.
- Src_Ready[i] = ~full[i] | grant[i]. This is pass-through, so one source can sustain one result per cycle.
- Capture:
  - Occurs at an edge where Src_Valid[i] & Src_Ready[i] & (Src_Tag[i]!=0).
  - Slot i loads value/tag and full[i]=1.
- Tag 0: Src_Valid with tag 0 is never captured. The slot is unchanged and no broadcast occurs.
- Broadcast, at an edge with grant[g]=1:
  - CDB<=slot[g].value, Qi_CDB<=slot[g].tag, CDB_Valid<=1.
  - full[g] clears unless a new capture into slot g occurs at the same edge; in that case the slot reloads and stays full.
  - ptr<=(g+1) mod N_SRC.
- Broadcast, at an edge with no grant: CDB<=IDLE_VALUE, Qi_CDB<=0, CDB_Valid<=0. ptr is unchanged.
- Latency: result accepted at edge k appears on CDB/Qi_CDB/CDB_Valid after edge k+1 at the earliest (no contention). With all N_SRC slots full, the worst-case wait is N_SRC broadcasts.
- Flush (Reset inactive):
  - All full bits clear; ptr=0.
  - Captures at that edge are discarded.
  - Outputs go to idle values at that edge.
- Priority: Reset > Flush > broadcast/capture.
- Reset mid-operation: pending results are lost and outputs go idle. No partial broadcast.
- No back-pressure from consumers: every broadcast is exactly one cycle wide.

Optional Feature:
Macro CDB_STATS_EN.
- Defined:
  - Adds output port Conflict_Count, 16 bits, registered.
  - Increments at each edge where 2 or more slots are full before capture.
  - Saturates at 16'hFFFF.
  - Cleared by Reset; not cleared by Flush.
- Undefined: port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Single source: src1 valid, Result=16'h0042, Tag=3 for one cycle -> next cycle CDB=16'h0042, Qi_CDB=3, CDB_Valid=1. Following cycle CDB=16'hFFF0, Qi_CDB=0, CDB_Valid=0.
- Contention: srcs 0..3 valid in the same cycle, tags 1,2,3,4, ptr=0 -> broadcasts tags 1,2,3,4 on four consecutive cycles. Src_Ready for waiting full slots =0 until granted. With CDB_STATS_EN, Conflict_Count=3.
- Fairness: after the previous test (ptr=0), srcs 0 and 2 keep Src_Valid=1 continuously -> CDB alternates tag(src0), tag(src2). Neither is starved.
- Streaming: src2 alone valid for 5 cycles, values 1..5, tag 5 -> Src_Ready[2] stays 1. CDB shows 1..5 on 5 consecutive cycles.
- Tag 0: src0 valid with Tag=0, Result=16'h1234 -> no capture. CDB_Valid stays 0 and CDB stays 16'hFFF0.
- Reset/Flush mid-operation: 3 slots full, then Reset=0 for one edge (repeat with Flush=1) -> CDB_Valid=0 next cycle, no stale tag ever broadcast, Src_Ready all ones, ptr restarts at 0 (next dual request src1+src3 grants src1 first).
